// File: rtl/start_screen_pkg.sv
// Shared types and geometry for the start-screen title sprite.
//   start_state_t : title/launch sequencing states
//   SPRITE_W/H    : title sprite box size in pixels
//   ROM_DEPTH     : sprite ROM word count (SPRITE_W * SPRITE_H)
//   ADDR_W        : sprite ROM address width
//   COORD_W       : DrawX/DrawY width
//   PIX_W         : palette index width
//   row_col_addr  : row*130 + col using shifts and adds only
package start_screen_pkg;

  localparam int unsigned SPRITE_W  = 130;
  localparam int unsigned SPRITE_H  = 31;
  localparam int unsigned ROM_DEPTH = SPRITE_W * SPRITE_H;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned PIX_W     = 4;

  typedef enum logic [1:0] {
    TITLE_ON  = 2'd0,
    TITLE_OFF = 2'd1,
    LAUNCH    = 2'd2,
    DONE      = 2'd3
  } start_state_t;

  // 130 = 128 + 2, so row*130 is (row<<7) + (row<<1). In-box operands keep the
  // result below ROM_DEPTH, so the 12-bit sum never wraps.
  function automatic logic [ADDR_W-1:0] row_col_addr(input logic [COORD_W-1:0] i_dx,
                                                      input logic [COORD_W-1:0] i_dy);
    return (ADDR_W'(i_dy) << 7) + (ADDR_W'(i_dy) << 1) + ADDR_W'(i_dx);
  endfunction

endpackage

// File: rtl/start_screen_drawer_if.sv
// Pixel/ROM/control bundle between the start-screen drawer and its neighbours.
//   frame_tick  : one-cycle pulse per frame
//   DrawX/DrawY : current pixel position
//   start_key   : level start key
//   rom_addr    : sprite ROM read address (drawer output)
//   rom_data    : sprite ROM palette index (drawer input)
//   pixel_index : palette index to colour mapper
//   pixel_valid : visible, opaque sprite pixel
//   game_start  : one-cycle pulse when the launch animation completes
// master = drawer side, slave = environment (timing, ROM, mapper, game logic).
interface start_screen_drawer_if;
  import start_screen_pkg::*;

  logic               frame_tick;
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               start_key;
  logic [ADDR_W-1:0]  rom_addr;
  logic [PIX_W-1:0]   rom_data;
  logic [PIX_W-1:0]   pixel_index;
  logic               pixel_valid;
  logic               game_start;

  modport master (
    input  frame_tick, DrawX, DrawY, start_key, rom_data,
    output rom_addr, pixel_index, pixel_valid, game_start
  );

  modport slave (
    output frame_tick, DrawX, DrawY, start_key, rom_data,
    input  rom_addr, pixel_index, pixel_valid, game_start
  );

endinterface

// File: rtl/sprite_addr_gen.sv
// Combinational sprite-box test and ROM address for a 130x31 sprite at (X0,Y0).
//   i_draw_x/i_draw_y : current pixel position
//   o_inbox_c         : pixel lies inside the sprite box
//   o_addr_c          : (y-Y0)*130 + (x-X0) inside the box, 0 outside
module sprite_addr_gen
  import start_screen_pkg::*;
#(
  parameter int unsigned X0 = 255,
  parameter int unsigned Y0 = 224
) (
  input  logic [COORD_W-1:0] i_draw_x,
  input  logic [COORD_W-1:0] i_draw_y,
  output logic               o_inbox_c,
  output logic [ADDR_W-1:0]  o_addr_c
);

  // One extra bit so box edges near the screen limit never overflow.
  localparam int unsigned EXT_W = COORD_W + 1;
  localparam logic [EXT_W-1:0] X_LO = EXT_W'(X0);
  localparam logic [EXT_W-1:0] X_HI = EXT_W'(X0 + SPRITE_W - 1);
  localparam logic [EXT_W-1:0] Y_LO = EXT_W'(Y0);
  localparam logic [EXT_W-1:0] Y_HI = EXT_W'(Y0 + SPRITE_H - 1);

  logic [EXT_W-1:0]   w_x_ext;
  logic [EXT_W-1:0]   w_y_ext;
  logic               w_in_x;
  logic               w_in_y;
  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;

  assign w_x_ext = {1'b0, i_draw_x};
  assign w_y_ext = {1'b0, i_draw_y};

  assign w_in_x = (w_x_ext >= X_LO) && (w_x_ext <= X_HI);
  assign w_in_y = (w_y_ext >= Y_LO) && (w_y_ext <= Y_HI);

  // Offsets are only meaningful in-box; out-of-box values are masked below.
  assign w_dx = i_draw_x - COORD_W'(X0);
  assign w_dy = i_draw_y - COORD_W'(Y0);

  assign o_inbox_c = w_in_x && w_in_y;
  assign o_addr_c  = o_inbox_c ? row_col_addr(w_dx, w_dy) : '0;

endmodule

// File: rtl/start_screen_drawer.sv
// Start-screen title drawer: drives the title sprite ROM from DrawX/DrawY,
// realigns its one-cycle read with the pixel, blinks the title per frame and
// plays a launch animation after a start-key press, ending in game_start.
//   Clk   : pixel clock
//   Reset : asynchronous, active-high
//   bus   : start_screen_drawer_if.master (frame_tick, DrawX/DrawY, start_key,
//           rom_addr/rom_data, pixel_index/pixel_valid, game_start)
// DrawX/DrawY to pixel_index/pixel_valid latency is 2 cycles.
module start_screen_drawer
  import start_screen_pkg::*;
#(
  parameter int unsigned X0            = 255,
  parameter int unsigned Y0            = 224,
  parameter int unsigned BLINK_FRAMES  = 30,
  parameter int unsigned LAUNCH_FRAMES = 60
) (
  input  logic                   Clk,
  input  logic                   Reset,
  start_screen_drawer_if.master  bus
);

  localparam int unsigned MAX_FRAMES = (BLINK_FRAMES > LAUNCH_FRAMES) ? BLINK_FRAMES
                                                                      : LAUNCH_FRAMES;
  // At least 3 bits: bit 2 drives the fast launch blink.
  localparam int unsigned CNT_W = ($clog2(MAX_FRAMES) < 3) ? 3 : $clog2(MAX_FRAMES);
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] LAUNCH_LAST = CNT_W'(LAUNCH_FRAMES - 1);

  start_state_t      r_state;
  start_state_t      w_state_next;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [CNT_W-1:0]  w_frame_cnt_next;
  logic              w_game_start_next;
  logic              r_key_q;
  logic              w_press;
  logic              w_vis;

  logic              w_inbox;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_inbox_d1;
  logic              r_vis_d1;
  logic [PIX_W-1:0]  r_pixel_index;
  logic              r_pixel_valid;
  logic              r_game_start;

  // Box test and address for the current pixel.
  sprite_addr_gen #(
    .X0 (X0),
    .Y0 (Y0)
  ) u_addr_gen (
    .i_draw_x  (bus.DrawX),
    .i_draw_y  (bus.DrawY),
    .o_inbox_c (w_inbox),
    .o_addr_c  (w_addr)
  );

  // Rising edge of the start key; key_q resets high so a held key is ignored.
  assign w_press = bus.start_key & ~r_key_q;

  // Visibility gate for the pixel entering stage 1.
  assign w_vis = (r_state == TITLE_ON) || ((r_state == LAUNCH) && !r_frame_cnt[2]);

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= TITLE_ON;
      r_frame_cnt  <= '0;
      r_game_start <= 1'b0;
      r_key_q      <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_frame_cnt  <= w_frame_cnt_next;
      r_game_start <= w_game_start_next;
      r_key_q      <= bus.start_key;
    end
  end

  // Next-state, frame counter and game_start decode.
  always_comb begin
    w_state_next      = r_state;
    w_frame_cnt_next  = r_frame_cnt;
    w_game_start_next = 1'b0;
    unique case (r_state)
      TITLE_ON, TITLE_OFF: begin
        // A press wins over a coincident frame_tick.
        if (w_press) begin
          w_state_next     = LAUNCH;
          w_frame_cnt_next = '0;
        end else if (bus.frame_tick) begin
          if (r_frame_cnt == BLINK_LAST) begin
            w_state_next     = (r_state == TITLE_ON) ? TITLE_OFF : TITLE_ON;
            w_frame_cnt_next = '0;
          end else begin
            w_frame_cnt_next = r_frame_cnt + CNT_W'(1);
          end
        end
      end
      LAUNCH: begin
        if (bus.frame_tick) begin
          if (r_frame_cnt == LAUNCH_LAST) begin
            w_state_next      = DONE;
            w_frame_cnt_next  = '0;
            w_game_start_next = 1'b1;
          end else begin
            w_frame_cnt_next = r_frame_cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        w_state_next = DONE;
      end
      default: begin
        w_state_next     = TITLE_ON;
        w_frame_cnt_next = '0;
      end
    endcase
  end

  // Stage 1: ROM address plus the flags that travel alongside it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rom_addr <= '0;
      r_inbox_d1 <= 1'b0;
      r_vis_d1   <= 1'b0;
    end else begin
      r_rom_addr <= w_addr;
      r_inbox_d1 <= w_inbox;
      r_vis_d1   <= w_vis;
    end
  end

  // Stage 2: ROM data lines up with its stage-1 flags; index 0 is transparent.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pixel_index <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_pixel_index <= bus.rom_data;
      r_pixel_valid <= r_inbox_d1 & r_vis_d1 & (bus.rom_data != '0);
    end
  end

  assign bus.rom_addr    = r_rom_addr;
  assign bus.pixel_index = r_pixel_index;
  assign bus.pixel_valid = r_pixel_valid;
  assign bus.game_start  = r_game_start;

endmodule

// File: tb/tb_start_screen_drawer.sv
// Bench for start_screen_drawer: directed sequences with literal expectations
// plus a randomized run, all checked each cycle against a frame-level model.
module tb_start_screen_drawer;
  import start_screen_pkg::*;

  localparam int unsigned X0 = 255;
  localparam int unsigned Y0 = 224;
  localparam int unsigned BF = 30;
  localparam int unsigned LF = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;

  start_screen_drawer_if bus ();

  start_screen_drawer #(
    .X0            (X0),
    .Y0            (Y0),
    .BLINK_FRAMES  (BF),
    .LAUNCH_FRAMES (LF)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Sprite ROM: rom_addr is the ROM's registered address, data follows it.
  logic [3:0] rom [ROM_DEPTH];
  assign bus.rom_data = (int'(bus.rom_addr) < int'(ROM_DEPTH)) ? rom[bus.rom_addr] : 4'd0;

  function automatic int rom_read(input int a);
    if (a >= 0 && a < int'(ROM_DEPTH)) return int'(rom[a]);
    return 0;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;
  int gs_cnt   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Title phase: visible while (ticks since reset / BF) is even.
  // Launch: visible for the first 4 of every 8 launch ticks; the LF-th tick ends it.
  int t_ticks, l_ticks;
  bit m_launch, m_done;
  bit key_prev;
  int exp_addr, exp_pix;
  bit exp_in1, exp_vis1, exp_valid, exp_gs;

  function automatic bit in_box(input int x, input int y);
    return (x >= int'(X0)) && (x < int'(X0 + SPRITE_W)) &&
           (y >= int'(Y0)) && (y < int'(Y0 + SPRITE_H));
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      t_ticks = 0; l_ticks = 0; m_launch = 0; m_done = 0; key_prev = 1;
      exp_addr = 0; exp_pix = 0; exp_in1 = 0; exp_vis1 = 0; exp_valid = 0; exp_gs = 0;
    end else begin
      bit vis_now, press, ib;
      int x, y, r;
      if (m_done)        vis_now = 0;
      else if (m_launch) vis_now = (l_ticks % 8) < 4;
      else               vis_now = ((t_ticks / int'(BF)) % 2) == 0;
      r = rom_read(exp_addr);
      exp_pix   = r;
      exp_valid = exp_in1 && exp_vis1 && (r != 0);
      x = int'(bus.DrawX);
      y = int'(bus.DrawY);
      ib = in_box(x, y);
      exp_in1  = ib;
      exp_vis1 = vis_now;
      exp_addr = ib ? (y - int'(Y0)) * int'(SPRITE_W) + (x - int'(X0)) : 0;
      press = bus.start_key && !key_prev;
      key_prev = bus.start_key;
      exp_gs = 0;
      if (m_done) begin
      end else if (m_launch) begin
        if (bus.frame_tick) begin
          if (l_ticks == int'(LF) - 1) begin
            exp_gs = 1; m_done = 1; m_launch = 0;
          end else l_ticks++;
        end
      end else if (press) begin
        m_launch = 1; l_ticks = 0;
      end else if (bus.frame_tick) begin
        t_ticks++;
      end
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    chk("rom_addr", int'(bus.rom_addr), exp_addr);
    chk("pixel_index", int'(bus.pixel_index), exp_pix);
    chk("pixel_valid", int'(bus.pixel_valid), int'(exp_valid));
    chk("game_start", int'(bus.game_start), int'(exp_gs));
  end

  initial forever begin
    @(negedge clk);
    if (bus.game_start) gs_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int x, input int y, input bit ft, input bit key);
    @(posedge clk);
    #2;
    bus.DrawX      = 10'(x);
    bus.DrawY      = 10'(y);
    bus.frame_tick = ft;
    bus.start_key  = key;
  endtask

  task automatic settle(input bit key);
    repeat (3) drive(255, 224, 0, key);
  endtask

  task automatic ticks(input int n, input bit key);
    repeat (n) begin
      drive(255, 224, 1, key);
      drive(255, 224, 0, key);
    end
  endtask

  task automatic do_reset(input bit key, input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.start_key  = key;
    bus.frame_tick = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    chk({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    chk({tag, "_pixel_index"}, int'(bus.pixel_index), 0);
    chk({tag, "_pixel_valid"}, int'(bus.pixel_valid), 0);
    chk({tag, "_game_start"}, int'(bus.game_start), 0);
    rst = 1'b0;
  endtask

  initial begin
    int gs_base;
    for (int i = 0; i < int'(ROM_DEPTH); i++) rom[i] = 4'($urandom_range(0, 15));
    rom[0]    = 4'd5;
    rom[1]    = 4'd0;
    rom[4029] = 4'd9;
    bus.frame_tick = 1'b0;
    bus.DrawX      = '0;
    bus.DrawY      = '0;
    bus.start_key  = 1'b0;

    do_reset(1'b0, "reset0");

    // Top-left corner of the box.
    drive(255, 224, 0, 0);
    drive(255, 224, 0, 0);
    chk("lit_corner_addr", int'(bus.rom_addr), 0);
    drive(255, 224, 0, 0);
    chk("lit_corner_index", int'(bus.pixel_index), 5);
    chk("lit_corner_valid", int'(bus.pixel_valid), 1);

    // Bottom-right corner, then one column past it.
    drive(384, 254, 0, 0);
    drive(385, 254, 0, 0);
    chk("lit_last_addr", int'(bus.rom_addr), 4029);
    drive(385, 254, 0, 0);
    chk("lit_oob_addr", int'(bus.rom_addr), 0);
    chk("lit_last_index", int'(bus.pixel_index), 9);
    chk("lit_last_valid", int'(bus.pixel_valid), 1);
    drive(385, 254, 0, 0);
    chk("lit_oob_valid", int'(bus.pixel_valid), 0);

    // Transparent in-box pixel.
    repeat (3) drive(256, 224, 0, 0);
    chk("lit_transp_index", int'(bus.pixel_index), 0);
    chk("lit_transp_valid", int'(bus.pixel_valid), 0);

    // Blink boundaries.
    ticks(29, 0); settle(0);
    chk("lit_blink29_valid", int'(bus.pixel_valid), 1);
    ticks(1, 0); settle(0);
    chk("lit_blink30_valid", int'(bus.pixel_valid), 0);
    ticks(29, 0); settle(0);
    chk("lit_off29_valid", int'(bus.pixel_valid), 0);
    ticks(1, 0); settle(0);
    chk("lit_back_on_valid", int'(bus.pixel_valid), 1);

    // Launch: press with a simultaneous tick (the tick is not counted).
    gs_base = gs_cnt;
    drive(255, 224, 1, 1);
    ticks(4, 1); settle(1);
    chk("lit_launch4_valid", int'(bus.pixel_valid), 0);
    ticks(55, 1); settle(1);
    chk("lit_launch59_valid", int'(bus.pixel_valid), 1);
    chk("lit_launch59_gs", gs_cnt - gs_base, 0);
    ticks(1, 1); settle(1);
    chk("lit_launch60_gs", gs_cnt - gs_base, 1);
    chk("lit_done_valid", int'(bus.pixel_valid), 0);
    repeat (10) begin
      drive(255, 224, 1, 0);
      drive(255, 224, 1, 1);
    end
    settle(0);
    chk("lit_done_press_gs", gs_cnt - gs_base, 1);
    chk("lit_done_press_valid", int'(bus.pixel_valid), 0);

    // Key held through reset is not a press.
    do_reset(1'b1, "reset_key");
    ticks(5, 1); settle(1);
    chk("lit_held_key_valid", int'(bus.pixel_valid), 1);
    drive(255, 224, 0, 0);
    drive(255, 224, 0, 1);
    ticks(5, 1); settle(1);
    chk("lit_repress_valid", int'(bus.pixel_valid), 0);

    // Abort the launch at tick 40.
    ticks(35, 1);
    gs_base = gs_cnt;
    do_reset(1'b0, "reset_abort");
    ticks(25, 0); settle(0);
    chk("lit_abort_gs", gs_cnt - gs_base, 0);
    chk("lit_abort_valid", int'(bus.pixel_valid), 1);

    // Randomized traffic around the box.
    begin
      bit key = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 39) == 0) key = ~key;
        drive(int'($urandom_range(240, 400)), int'($urandom_range(215, 260)),
              ($urandom_range(0, 2) == 0), key);
        if ($urandom_range(0, 399) == 0) begin
          @(posedge clk);
          #2;
          rst = 1'b1;
          @(posedge clk);
          #2;
          rst = 1'b0;
        end
      end
    end

    settle(0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
